// File: rtl/time_pkg.sv
// Shared field layouts, limits, reset constants and calendar helper
// for the time/date keeper and its key-controller interface.
package time_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int YEAR_W  = 7;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int TIME_W  = HOUR_W + MIN_W + SEC_W;
  localparam int DATE_W  = YEAR_W + MONTH_W + DAY_W;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
  } date_t;

  typedef enum logic {
    IDLE,
    ACK
  } hs_state_t;

  localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
  localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
  localparam logic [YEAR_W-1:0]  YEAR_MAX  = 7'd99;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;

  localparam time_t TIME_RST  = 17'd1;
  localparam date_t DATE_RST  = {7'd16, 4'd1, 5'd1};
  localparam time_t ALARM_RST = 17'd0;

  // Years are 2000-based and stay within 2000..2099, so year%4 alone decides leap.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic [YEAR_W-1:0] year);
    case (month)
      4'd2:                 return (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:              return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/time_date_keeper_if.sv
// Setting/alarm interface between the key controller (master) and the
// time/date keeper (slave).
interface time_date_keeper_if;
  import time_pkg::*;

  logic              setting;
  logic              alarm_setting;
  logic [TIME_W-1:0] set_time;
  logic [DATE_W-1:0] set_date;
  logic [TIME_W-1:0] set_alarm_time;
  logic              hold;
  logic              alarm_enable;
  logic              alarm_clear;
  logic              setting_ok;
  logic [TIME_W-1:0] in_time;
  logic [DATE_W-1:0] in_date;
  logic [TIME_W-1:0] in_alarm_time;
  logic              alarm_ring;

  modport master (
    output setting, alarm_setting, set_time, set_date, set_alarm_time,
    output hold, alarm_enable, alarm_clear,
    input  setting_ok, in_time, in_date, in_alarm_time, alarm_ring
  );

  modport slave (
    input  setting, alarm_setting, set_time, set_date, set_alarm_time,
    input  hold, alarm_enable, alarm_clear,
    output setting_ok, in_time, in_date, in_alarm_time, alarm_ring
  );
endinterface

// File: rtl/time_date_keeper_tick_gen.sv
// One-second prescaler: counts CLK cycles, pulses tick on the last count,
// freezes under hold and restarts from zero on clear.
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic hold,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = !hold && (count == CW'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/time_date_keeper.sv
// Running clock/calendar with alarm register, serving load requests from the
// key controller through a two-state acknowledge handshake.
module time_date_keeper
  import time_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int RING_SEC = 30
) (
  input logic          CLK,
  input logic          RESET,
  time_date_keeper_if.slave bus
);
  localparam int RING_W = (RING_SEC < 2) ? 1 : $clog2(RING_SEC + 1);

  hs_state_t         state, state_nxt;
  logic              load_time, load_alarm;
  logic              tick, tick_taken;
  logic              upd_p1, match, alarm_ring;
  logic [RING_W-1:0] ring_cnt;
  time_t             cur_time, time_inc, alarm_time;
  date_t             cur_date, date_inc;

  function automatic time_t clamp_time(input time_t t);
    time_t r;
    r = t;
    if (t.hour > HOUR_MAX) r.hour = HOUR_MAX;
    if (t.min > MIN_MAX)   r.min  = MIN_MAX;
    if (t.sec > SEC_MAX)   r.sec  = SEC_MAX;
    return r;
  endfunction

  // Day limit depends on the already-clamped month and year.
  function automatic date_t clamp_date(input date_t d);
    date_t            r;
    logic [DAY_W-1:0] lim;
    r = d;
    if (d.year > YEAR_MAX) r.year = YEAR_MAX;
    if (d.month == '0)           r.month = 4'd1;
    else if (d.month > MONTH_MAX) r.month = MONTH_MAX;
    lim = days_in_month(r.month, r.year);
    if (d.day == '0)     r.day = 5'd1;
    else if (d.day > lim) r.day = lim;
    return r;
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .hold  (bus.hold),
    .clear (load_time),
    .tick  (tick)
  );

  // A load in the same cycle discards the tick.
  assign tick_taken = tick && !load_time;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_time  = 1'b0;
    load_alarm = 1'b0;
    case (state)
      IDLE: begin
        if (bus.setting || bus.alarm_setting) begin
          state_nxt  = ACK;
          load_time  = bus.setting;
          load_alarm = bus.alarm_setting;
        end
      end
      ACK: begin
        if (!bus.setting && !bus.alarm_setting) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    time_inc = cur_time;
    date_inc = cur_date;
    if (cur_time.sec < SEC_MAX) begin
      time_inc.sec = cur_time.sec + 6'd1;
    end else begin
      time_inc.sec = '0;
      if (cur_time.min < MIN_MAX) begin
        time_inc.min = cur_time.min + 6'd1;
      end else begin
        time_inc.min = '0;
        if (cur_time.hour < HOUR_MAX) begin
          time_inc.hour = cur_time.hour + 5'd1;
        end else begin
          time_inc.hour = '0;
          if (cur_date.day < days_in_month(cur_date.month, cur_date.year)) begin
            date_inc.day = cur_date.day + 5'd1;
          end else begin
            date_inc.day = 5'd1;
            if (cur_date.month < MONTH_MAX) begin
              date_inc.month = cur_date.month + 4'd1;
            end else begin
              date_inc.month = 4'd1;
              date_inc.year  = (cur_date.year < YEAR_MAX) ? cur_date.year + 7'd1 : '0;
            end
          end
        end
      end
    end
  end

  // Stage p0: time/date and alarm registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur_time <= TIME_RST;
      cur_date <= DATE_RST;
    end else if (load_time) begin
      cur_time <= clamp_time(bus.set_time);
      cur_date <= clamp_date(bus.set_date);
    end else if (tick_taken) begin
      cur_time <= time_inc;
      cur_date <= date_inc;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           alarm_time <= ALARM_RST;
    else if (load_alarm) alarm_time <= clamp_time(bus.set_alarm_time);
  end

  // Stage p1: compare the freshly updated time against the alarm
  assign match = upd_p1 && bus.alarm_enable && (cur_time == alarm_time);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      upd_p1     <= 1'b0;
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else begin
      upd_p1 <= tick_taken || load_time;
      if (bus.alarm_clear || !bus.alarm_enable) begin
        alarm_ring <= 1'b0;
        ring_cnt   <= '0;
      end else if (match) begin
        alarm_ring <= 1'b1;
        ring_cnt   <= RING_W'(RING_SEC);
      end else if (tick_taken && ring_cnt != '0) begin
        ring_cnt <= ring_cnt - RING_W'(1);
        if (ring_cnt == RING_W'(1)) alarm_ring <= 1'b0;
      end
    end
  end

  assign bus.setting_ok    = (state == ACK);
  assign bus.in_time       = cur_time;
  assign bus.in_date       = cur_date;
  assign bus.in_alarm_time = alarm_time;
  assign bus.alarm_ring    = alarm_ring;

endmodule
